// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
// Holds the fetch FSM encoding, default bus widths and instruction length codes.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEFAULT   = 8;
  localparam int unsigned DATA_W_DEFAULT   = 8;
  localparam int unsigned LONG_BIT_DEFAULT = 7;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StReqOp,
    StWaitOp,
    StReqImm,
    StWaitImm,
    StHold,
    StDrain
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of PC, memory-read and decoder handshake signals around the fetch unit.
// master is the fetch unit side; slave is the PC/memory/decoder side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W_DEFAULT
) ();

  logic [ADDR_W-1:0] pc_in;
  logic              pc_adv;
  logic [1:0]        pc_step;
  logic              flush;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_opcode;
  logic [DATA_W-1:0] instr_imm;
  logic [ADDR_W-1:0] instr_pc;
  logic [1:0]        instr_len;

  modport master (
    input  pc_in, flush, mem_req_ready, mem_rsp_valid, mem_rdata, instr_ready,
    output pc_adv, pc_step, mem_req_valid, mem_addr,
    output instr_valid, instr_opcode, instr_imm, instr_pc, instr_len
  );

  modport slave (
    output pc_in, flush, mem_req_ready, mem_rsp_valid, mem_rdata, instr_ready,
    input  pc_adv, pc_step, mem_req_valid, mem_addr,
    input  instr_valid, instr_opcode, instr_imm, instr_pc, instr_len
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch: reads 1- or 2-byte instructions at pc_in, holds one for the
// decoder and pulses pc_adv on consumption. flush redirects, draining any in-flight read.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned LONG_BIT = LONG_BIT_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] imm_q;
  logic [1:0]        len_q;
  logic              consume;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      opcode_q <= '0;
      imm_q    <= '0;
      len_q    <= 2'd0;
    end else begin
      case (state_q)
        StIdle: state_q <= StReqOp;
        StReqOp: begin
          pc_q <= bus.pc_in;
          // An accepted request is outstanding even if flushed; its response must be drained.
          if (bus.mem_req_ready) state_q <= bus.flush ? StDrain : StWaitOp;
        end
        StWaitOp: begin
          if (bus.mem_rsp_valid) begin
            if (bus.flush) begin
              state_q <= StReqOp;
            end else begin
              opcode_q <= bus.mem_rdata;
              if (bus.mem_rdata[LONG_BIT]) begin
                state_q <= StReqImm;
              end else begin
                imm_q   <= '0;
                len_q   <= LEN_1;
                state_q <= StHold;
              end
            end
          end else if (bus.flush) begin
            state_q <= StDrain;
          end
        end
        StReqImm: begin
          if (bus.mem_req_ready) state_q <= bus.flush ? StDrain : StWaitImm;
          else if (bus.flush)    state_q <= StReqOp;
        end
        StWaitImm: begin
          if (bus.mem_rsp_valid) begin
            if (bus.flush) begin
              state_q <= StReqOp;
            end else begin
              imm_q   <= bus.mem_rdata;
              len_q   <= LEN_2;
              state_q <= StHold;
            end
          end else if (bus.flush) begin
            state_q <= StDrain;
          end
        end
        StHold: begin
          if (bus.flush || bus.instr_ready) state_q <= StReqOp;
        end
        StDrain: begin
          if (bus.mem_rsp_valid) state_q <= StReqOp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A flush in the handshake cycle squashes the instruction, so the PC must not move.
  assign consume = (state_q == StHold) && bus.instr_ready && !bus.flush;

  assign bus.pc_adv        = consume;
  assign bus.pc_step       = consume ? len_q : 2'd0;
  assign bus.mem_req_valid = (state_q == StReqOp) || (state_q == StReqImm);
  assign bus.instr_valid   = (state_q == StHold);
  assign bus.instr_opcode  = opcode_q;
  assign bus.instr_imm     = imm_q;
  assign bus.instr_pc      = pc_q;
  assign bus.instr_len     = len_q;

  always_comb begin
    bus.mem_addr = '0;
    if (state_q == StReqOp) begin
      bus.mem_addr = bus.pc_in;
    end else if (state_q == StReqImm) begin
      bus.mem_addr = pc_q + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a byte-array
// memory model and an instruction-level reference (opcode at PC, optional immediate at PC+1).
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .LONG_BIT(7)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mem [256];
  int         rsp_due[$];
  logic [7:0] rsp_dat[$];

  // Stimulus knobs applied at the start of the next cycle.
  logic       k_ready, k_iready, k_flush;
  logic [7:0] k_flush_pc;
  int         k_lat;

  // Mid-cycle samples.
  logic       s_valid, s_req, s_acc, s_adv, s_flush, s_iready;
  logic [7:0] s_addr, s_op, s_imm, s_ipc, s_pcin;
  logic [1:0] s_step, s_len;

  task automatic set_defaults();
    k_ready = 1'b1; k_iready = 1'b1; k_flush = 1'b0; k_flush_pc = 8'h00; k_lat = 1;
  endtask

  // One clock: drive inputs just after the edge, sample mid-cycle, model memory and PC.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      rsp_due.delete();
      rsp_dat.delete();
    end
    if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = rsp_dat[0];
      void'(rsp_due.pop_front());
      void'(rsp_dat.pop_front());
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = 8'($urandom);
    end
    bus.mem_req_ready = k_ready;
    bus.instr_ready   = k_iready;
    bus.flush         = k_flush;
    if (k_flush) bus.pc_in = k_flush_pc;
    @(negedge clk);
    s_valid  = bus.instr_valid;
    s_req    = bus.mem_req_valid;
    s_acc    = bus.mem_req_valid && bus.mem_req_ready;
    s_adv    = bus.pc_adv;
    s_flush  = bus.flush;
    s_iready = bus.instr_ready;
    s_addr   = bus.mem_addr;
    s_op     = bus.instr_opcode;
    s_imm    = bus.instr_imm;
    s_ipc    = bus.instr_pc;
    s_pcin   = bus.pc_in;
    s_step   = bus.pc_step;
    s_len    = bus.instr_len;
    if (s_acc) begin
      rsp_due.push_back(cyc + 1 + k_lat);
      rsp_dat.push_back(mem[s_addr]);
    end
    if (s_adv) bus.pc_in = bus.pc_in + 8'(s_step);
  endtask

  task automatic do_reset(input logic [7:0] pc);
    reset = 1'b0;
    bus.pc_in = pc;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_defaults();
    reset = 1'b1;
    #2 reset = 1'b0;
    bus.pc_in = 8'h05;
    cycle();
    cycle();
    checks++; if ({s_valid, s_req, s_adv} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b expected 000", {s_valid, s_req, s_adv}); end
    checks++; if ({s_addr, s_op, s_imm, s_ipc, s_step, s_len} !== 36'd0) begin errors++;
      $display("FAIL reset_values: got %h expected 0", {s_addr, s_op, s_imm, s_ipc, s_step, s_len}); end
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL reset_idle: got req %b expected 0", bus.mem_req_valid); end
    cycle();
    checks++; if (s_req !== 1'b1 || s_addr !== 8'h05) begin errors++;
      $display("FAIL reset_first_req: got %b/%h expected 1/05", s_req, s_addr); end
  endtask

  task automatic test_short();
    int  acc_cyc = -1;
    bit  done = 0;
    set_defaults();
    mem[8'h00] = 8'h12;
    do_reset(8'h00);
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (s_acc && acc_cyc < 0) begin
        acc_cyc = cyc;
        checks++; if (s_addr !== 8'h00) begin errors++;
          $display("FAIL short_addr: got %h expected 00", s_addr); end
      end
      if (s_valid) begin
        done = 1;
        checks++; if ({s_op, s_imm, s_len, s_ipc} !== {8'h12, 8'h00, 2'd1, 8'h00}) begin errors++;
          $display("FAIL short_instr: got %h/%h/%0d/%h expected 12/00/1/00", s_op, s_imm, s_len, s_ipc); end
        checks++; if (s_adv !== 1'b1 || s_step !== 2'd1) begin errors++;
          $display("FAIL short_adv: got %b/%0d expected 1/1", s_adv, s_step); end
        checks++; if (cyc - acc_cyc != 3) begin errors++;
          $display("FAIL short_latency: got %0d expected 3", cyc - acc_cyc); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL short_timeout: got none expected instr"); end
  endtask

  task automatic test_long_instr(input logic [7:0] pc, input logic [7:0] op, input logic [7:0] imm);
    logic [7:0] addrs[$];
    logic [7:0] pc1;
    bit done = 0;
    pc1 = pc + 8'd1;
    set_defaults();
    mem[pc]  = op;
    mem[pc1] = imm;
    do_reset(pc);
    for (int i = 0; i < 30 && !done; i++) begin
      cycle();
      if (s_acc) addrs.push_back(s_addr);
      if (s_valid) begin
        done = 1;
        checks++; if (addrs.size() != 2 || addrs[0] !== pc || addrs[1] !== pc1) begin errors++;
          $display("FAIL long_addrs@%h: got %p expected %h,%h", pc, addrs, pc, pc1); end
        checks++; if ({s_op, s_imm, s_len, s_ipc} !== {op, imm, 2'd2, pc}) begin errors++;
          $display("FAIL long_instr@%h: got %h/%h/%0d/%h expected %h/%h/2/%h",
                   pc, s_op, s_imm, s_len, s_ipc, op, imm, pc); end
        checks++; if (s_adv !== 1'b1 || s_step !== 2'd2) begin errors++;
          $display("FAIL long_adv@%h: got %b/%0d expected 1/2", pc, s_adv, s_step); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL long_timeout@%h: got none expected instr", pc); end
  endtask

  task automatic test_stall();
    int stall = 0, held = 0, advs = 0, acc_cyc = -1, first_valid = -1;
    set_defaults();
    k_ready = 1'b0; k_lat = 3; k_iready = 1'b0;
    mem[8'h20] = 8'h05; mem[8'h21] = 8'h06;
    do_reset(8'h20);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (s_req && !s_acc && acc_cyc < 0) begin
        stall++;
        checks++; if (s_addr !== 8'h20) begin errors++;
          $display("FAIL stall_addr: got %h expected 20", s_addr); end
        if (stall == 4) k_ready = 1'b1;
      end
      if (s_acc && acc_cyc < 0) acc_cyc = cyc;
      if (s_valid && first_valid < 0) first_valid = cyc;
      if (s_valid && !s_iready && advs == 0) begin
        held++;
        if (held == 5) k_iready = 1'b1;
      end
      if (s_adv) begin
        if (advs == 0) begin
          checks++; if (s_op !== 8'h05 || s_step !== 2'd1) begin errors++;
            $display("FAIL stall_consume: got %h/%0d expected 05/1", s_op, s_step); end
        end
        advs++;
        k_iready = 1'b0;
      end
    end
    checks++; if (stall != 4) begin errors++; $display("FAIL stall_cycles: got %0d expected 4", stall); end
    checks++; if (first_valid - acc_cyc != 5) begin errors++;
      $display("FAIL stall_latency: got %0d expected 5", first_valid - acc_cyc); end
    checks++; if (held != 5) begin errors++; $display("FAIL stall_held: got %0d expected 5", held); end
    checks++; if (advs != 1) begin errors++; $display("FAIL stall_adv_count: got %0d expected 1", advs); end
  endtask

  task automatic test_flush();
    int nacc = 0, acc_cyc = -1;
    bit done = 0;
    set_defaults();
    k_lat = 2;
    mem[8'h30] = 8'h44; mem[8'h40] = 8'h22;
    do_reset(8'h30);
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      if (s_flush) k_flush = 1'b0;
      if (s_acc) begin
        nacc++;
        if (nacc == 1) begin
          acc_cyc = cyc;
          k_flush = 1'b1; k_flush_pc = 8'h40;
        end else if (nacc == 2) begin
          checks++; if (s_addr !== 8'h40 || cyc != acc_cyc + 4) begin errors++;
            $display("FAIL flush_refetch: got %h@+%0d expected 40@+4", s_addr, cyc - acc_cyc); end
        end
      end
      if (s_adv && !s_valid) begin errors++; $display("FAIL flush_adv: got stray pc_adv"); end
      if (s_valid) begin
        done = 1;
        checks++; if (s_op !== 8'h22 || s_ipc !== 8'h40) begin errors++;
          $display("FAIL flush_instr: got %h@%h expected 22@40", s_op, s_ipc); end
        checks++; if (s_adv !== 1'b1) begin errors++;
          $display("FAIL flush_adv_new: got %b expected 1", s_adv); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL flush_timeout: got none expected instr"); end
  endtask

  task automatic test_reset_hold();
    logic [38:0] v;
    bit seen = 0, done = 0, acc = 0;
    set_defaults();
    k_iready = 1'b0;
    mem[8'h50] = 8'h07; mem[8'h60] = 8'h09;
    do_reset(8'h50);
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (s_valid) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_timeout: got none expected instr"); end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    v = {bus.instr_valid, bus.mem_req_valid, bus.pc_adv, bus.pc_step, bus.mem_addr,
         bus.instr_opcode, bus.instr_imm, bus.instr_pc, bus.instr_len};
    checks++; if (v !== 39'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", v); end
    bus.pc_in = 8'h60;
    k_iready = 1'b1;
    cycle();
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (s_acc && !acc) begin
        acc = 1;
        checks++; if (s_addr !== 8'h60) begin errors++;
          $display("FAIL restart_addr: got %h expected 60", s_addr); end
      end
      if (s_valid) begin
        done = 1;
        checks++; if (!acc || s_op !== 8'h09 || s_ipc !== 8'h60) begin errors++;
          $display("FAIL restart_instr: got %h@%h expected 09@60", s_op, s_ipc); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL restart_timeout: got none expected instr"); end
  endtask

  task automatic test_random();
    int         hs = 0;
    bit         prev_flush = 0;
    logic [7:0] e_op, e_imm, pc1;
    logic [1:0] e_len;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    set_defaults();
    do_reset(8'($urandom));
    for (int i = 0; i < 3000; i++) begin
      k_ready    = ($urandom_range(0, 3) != 0);
      k_iready   = ($urandom_range(0, 2) != 0);
      k_lat      = $urandom_range(1, 3);
      k_flush    = ($urandom_range(0, 29) == 0);
      k_flush_pc = 8'($urandom);
      cycle();
      pc1   = s_pcin + 8'd1;
      e_op  = mem[s_pcin];
      e_len = e_op[7] ? 2'd2 : 2'd1;
      e_imm = e_op[7] ? mem[pc1] : 8'h00;
      if (prev_flush) begin
        checks++; if (s_valid !== 1'b0) begin errors++;
          $display("FAIL rnd_valid_after_flush: got %b expected 0 at cycle %0d", s_valid, cyc); end
      end
      if (s_valid && s_iready && !s_flush) begin
        hs++;
        checks++; if ({s_op, s_imm, s_len, s_ipc} !== {e_op, e_imm, e_len, s_pcin}) begin errors++;
          $display("FAIL rnd_instr: got %h/%h/%0d/%h expected %h/%h/%0d/%h",
                   s_op, s_imm, s_len, s_ipc, e_op, e_imm, e_len, s_pcin); end
        checks++; if (s_adv !== 1'b1 || s_step !== e_len) begin errors++;
          $display("FAIL rnd_adv: got %b/%0d expected 1/%0d", s_adv, s_step, e_len); end
      end else begin
        checks++; if (s_adv !== 1'b0) begin errors++;
          $display("FAIL rnd_no_adv: got %b expected 0 at cycle %0d", s_adv, cyc); end
      end
      if (s_acc && !s_flush) begin
        checks++; if (!(s_addr === s_pcin || (e_op[7] && s_addr === pc1))) begin errors++;
          $display("FAIL rnd_addr: got %h expected %h or %h", s_addr, s_pcin, pc1); end
      end
      prev_flush = s_flush;
    end
    checks++; if (hs < 100) begin errors++; $display("FAIL rnd_progress: got %0d expected >=100", hs); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    bus.pc_in = 8'h00; bus.flush = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 8'h00; bus.instr_ready = 1'b0;
    test_reset();
    test_short();
    test_long_instr(8'h10, 8'h85, 8'h3C);
    test_long_instr(8'hFF, 8'h80, 8'h7E);
    test_stall();
    test_flush();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
